// File: rtl/bcd_time_entry.sv
// bcd_time_entry: microwave-style keypad time entry.
// Digits shift in from the right (m:ss, three BCD digits). The enter key
// validates the value and commits it with a one-cycle strobe.
// Optional build macro: SEC_TENS_NORMALIZE_EN -- when defined, an enter
// with tens-of-seconds above 5 carries into the minutes digit (0:75 -> 1:15)
// instead of being rejected, unless minutes is already 9.
module bcd_time_entry (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       timer_busy,
  output logic       key_ready,
  output logic [3:0] min,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       entry_active,
  output logic       time_valid,
  output logic       entry_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  state_t     state_reg, state_next;
  logic [1:0] count_reg, count_next;
  logic [3:0] min_reg, min_next;
  logic [3:0] tens_reg, tens_next;
  logic [3:0] ones_reg, ones_next;
  logic       error_reg, error_next;

  logic accept;
  logic is_digit;

  assign key_ready = (state_reg != COMMIT) && !timer_busy;
  assign accept    = key_valid && key_ready;
  assign is_digit  = (key_code <= 4'd9);

  // State, digit count, digits and the reject strobe register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= 2'd0;
      min_reg   <= 4'd0;
      tens_reg  <= 4'd0;
      ones_reg  <= 4'd0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      min_reg   <= min_next;
      tens_reg  <= tens_next;
      ones_reg  <= ones_next;
      error_reg <= error_next;
    end
  end

  // Key decode and next-state logic; anything unaccepted holds everything.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    min_next   = min_reg;
    tens_next  = tens_reg;
    ones_next  = ones_reg;
    error_next = 1'b0;

    if (state_reg == COMMIT) begin
      // Commit is a single-cycle strobe; digits are held for the consumer.
      state_next = IDLE;
    end else if (accept) begin
      if (is_digit) begin
        if (state_reg == IDLE) begin
          // First digit of a new entry wipes the previously shown value.
          min_next   = 4'd0;
          tens_next  = 4'd0;
          ones_next  = key_code;
          count_next = 2'd1;
          state_next = ENTRY;
        end else if (count_reg < 2'd3) begin
          min_next   = tens_reg;
          tens_next  = ones_reg;
          ones_next  = key_code;
          count_next = count_reg + 2'd1;
        end
        // A fourth digit is consumed without effect.
      end else if (key_code == KEY_CLEAR) begin
        min_next   = 4'd0;
        tens_next  = 4'd0;
        ones_next  = 4'd0;
        count_next = 2'd0;
        state_next = IDLE;
      end else if ((key_code == KEY_ENTER) && (count_reg != 2'd0)) begin
        if (tens_reg <= 4'd5) begin
          count_next = 2'd0;
          state_next = COMMIT;
        end
`ifdef SEC_TENS_NORMALIZE_EN
        else if (min_reg < 4'd9) begin
          // Carry 60 seconds into the minutes digit.
          min_next   = min_reg + 4'd1;
          tens_next  = tens_reg - 4'd6;
          count_next = 2'd0;
          state_next = COMMIT;
        end
`endif
        else begin
          error_next = 1'b1;
          min_next   = 4'd0;
          tens_next  = 4'd0;
          ones_next  = 4'd0;
          count_next = 2'd0;
          state_next = IDLE;
        end
      end
      // Codes C-F, and enter with nothing typed, are consumed silently.
    end
  end

  assign min          = min_reg;
  assign sec_tens     = tens_reg;
  assign sec_ones     = ones_reg;
  assign entry_active = (state_reg == ENTRY);
  assign time_valid   = (state_reg == COMMIT);
  assign entry_error  = error_reg;

endmodule

// File: tb/tb_bcd_time_entry.sv
// Testbench for bcd_time_entry: table of per-cycle vectors with
// hand-computed expectations, plus an asynchronous reset sequence.
module tb_bcd_time_entry;

  logic       clk;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       timer_busy;
  logic       key_ready;
  logic [3:0] min;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       entry_active;
  logic       time_valid;
  logic       entry_error;

  int checks = 0;
  int errors = 0;

  bcd_time_entry dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .timer_busy   (timer_busy),
    .key_ready    (key_ready),
    .min          (min),
    .sec_tens     (sec_tens),
    .sec_ones     (sec_ones),
    .entry_active (entry_active),
    .time_valid   (time_valid),
    .entry_error  (entry_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       kv;
    logic [3:0] code;
    logic       busy;
    logic [3:0] emin;
    logic [3:0] etens;
    logic [3:0] eones;
    logic       eact;
    logic       eval;
    logic       eerr;
    logic       erdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic kv, input logic [3:0] code, input logic busy,
                     input logic [3:0] emin, input logic [3:0] etens, input logic [3:0] eones,
                     input logic eact, input logic eval, input logic eerr, input logic erdy);
    vec_t v;
    v.kv = kv; v.code = code; v.busy = busy;
    v.emin = emin; v.etens = etens; v.eones = eones;
    v.eact = eact; v.eval = eval; v.eerr = eerr; v.erdy = erdy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [3:0] emin, input logic [3:0] etens,
                           input logic [3:0] eones, input logic eact, input logic eval,
                           input logic eerr, input logic erdy);
    chk("min", idx, min, emin);
    chk("sec_tens", idx, sec_tens, etens);
    chk("sec_ones", idx, sec_ones, eones);
    chk("entry_active", idx, {3'b0, entry_active}, {3'b0, eact});
    chk("time_valid", idx, {3'b0, time_valid}, {3'b0, eval});
    chk("entry_error", idx, {3'b0, entry_error}, {3'b0, eerr});
    chk("key_ready", idx, {3'b0, key_ready}, {3'b0, erdy});
  endtask

  // Apply one key for a single cycle, no check.
  task automatic press(input logic [3:0] code);
    key_valid = 1'b1; key_code = code; timer_busy = 1'b0;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  initial begin
    // Reset and basic entry 1,3,0,enter
    add(1, 4'h1, 0, 0, 0, 1, 1, 0, 0, 1);
    add(1, 4'h3, 0, 0, 1, 3, 1, 0, 0, 1);
    add(1, 4'h0, 0, 1, 3, 0, 1, 0, 0, 1);
    add(1, 4'hB, 0, 1, 3, 0, 0, 1, 0, 0);
    add(0, 4'h0, 0, 1, 3, 0, 0, 0, 0, 1);
    // Overflow and clear
    add(1, 4'h4, 0, 0, 0, 4, 1, 0, 0, 1);
    add(1, 4'h5, 0, 0, 4, 5, 1, 0, 0, 1);
    add(1, 4'h6, 0, 4, 5, 6, 1, 0, 0, 1);
    add(1, 4'h7, 0, 4, 5, 6, 1, 0, 0, 1);
    add(1, 4'hA, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 4'hB, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Invalid seconds 7,5,enter
    add(1, 4'h7, 0, 0, 0, 7, 1, 0, 0, 1);
    add(1, 4'h5, 0, 0, 7, 5, 1, 0, 0, 1);
`ifdef SEC_TENS_NORMALIZE_EN
    add(1, 4'hB, 0, 1, 1, 5, 0, 1, 0, 0);
    add(0, 4'h0, 0, 1, 1, 5, 0, 0, 0, 1);
`else
    add(1, 4'hB, 0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1);
`endif
    // 9:75 is rejected in either build
    add(1, 4'h9, 0, 0, 0, 9, 1, 0, 0, 1);
    add(1, 4'h7, 0, 0, 9, 7, 1, 0, 0, 1);
    add(1, 4'h5, 0, 9, 7, 5, 1, 0, 0, 1);
    add(1, 4'hB, 0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Busy lock: 2,1 then 5 held while busy
    add(1, 4'h2, 0, 0, 0, 2, 1, 0, 0, 1);
    add(1, 4'h1, 0, 0, 2, 1, 1, 0, 0, 1);
    add(1, 4'h5, 1, 0, 2, 1, 1, 0, 0, 0);
    add(1, 4'h5, 1, 0, 2, 1, 1, 0, 0, 0);
    add(1, 4'h5, 0, 2, 1, 5, 1, 0, 0, 1);
    // Back-to-back: enter, then 8 held across COMMIT
    add(1, 4'hB, 0, 2, 1, 5, 0, 1, 0, 0);
    add(1, 4'h8, 0, 2, 1, 5, 0, 0, 0, 1);
    add(1, 4'h8, 0, 0, 0, 8, 1, 0, 0, 1);
    add(1, 4'hE, 0, 0, 0, 8, 1, 0, 0, 1);
    add(1, 4'hF, 0, 0, 0, 8, 1, 0, 0, 1);
    add(0, 4'h0, 0, 0, 0, 8, 1, 0, 0, 1);
    // Ignored code in IDLE after clear
    add(1, 4'hA, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 4'hC, 0, 0, 0, 0, 0, 0, 0, 1);

    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0; timer_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all(-1, 0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      key_valid  = vecs[i].kv;
      key_code   = vecs[i].code;
      timer_busy = vecs[i].busy;
      @(posedge clk); #1;
      check_all(i, vecs[i].emin, vecs[i].etens, vecs[i].eones,
                vecs[i].eact, vecs[i].eval, vecs[i].eerr, vecs[i].erdy);
      $display("vec %0d: key_valid=%0d code=%0h busy=%0d -> %0d:%0d%0d act=%0d tv=%0d err=%0d rdy=%0d",
               i, vecs[i].kv, vecs[i].code, vecs[i].busy, min, sec_tens, sec_ones,
               entry_active, time_valid, entry_error, key_ready);
    end

    // Asynchronous reset mid-entry: 3,2 then drop rst_n between edges
    press(4'h3);
    press(4'h2);
    check_all(100, 0, 3, 2, 1, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all(101, 0, 0, 0, 0, 0, 0, 1);
    $display("async reset: %0d:%0d%0d act=%0d tv=%0d", min, sec_tens, sec_ones, entry_active, time_valid);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_all(102 + i, 0, 0, 0, 0, 0, 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
